alu_result_buffer: RTL and testbench

Registered output stage placed directly downstream of the combinational ALU. It captures `ALU_Out`, `Alu_Flags` and the selector that produced them into a 2-entry valid/ready buffer, which breaks the combinational path from operands to the consumer. It also keeps sticky exception flags, filtered by operation, so software or control can poll them.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_result_buffer_if.sv | 25 ++
 rtl/alu_flag_filter.sv | 21 ++
 rtl/alu_result_buffer.sv | 87 ++++++++
 tb/tb_alu_result_buffer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, flag index and result-buffer state definitions
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3,
        MOD = 4'd4,
        AND = 4'd5,
        OR  = 4'd6,
        XOR = 4'd7,
        SHL = 4'd8,
        SHR = 4'd9
    } alu_op_e;

    localparam int FLG_MUL_OVF = 0;
    localparam int FLG_CARRY   = 1;
    localparam int FLG_DIVZ    = 2;
    localparam int FLG_BORROW  = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic logic [1:0] level_of(buf_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - valid/ready producer and consumer signals of the ALU result buffer
interface alu_result_buffer_if #(
    parameter int M = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_result;
    logic [3:0]   in_flags;
    logic [3:0]   in_sel;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_result;
    logic [3:0]   out_flags;
    logic [3:0]   out_sel;

    modport master (
        output in_valid, in_result, in_flags, in_sel, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_sel
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_sel, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_sel
    );
endinterface

// File: rtl/alu_flag_filter.sv
// rtl/alu_flag_filter.sv - keeps only the exception flag owned by the producing ALU operation
module alu_flag_filter
    import alu_pkg::*;
(
    input  logic [3:0] sel_i,
    input  logic [3:0] flags_i,
    output logic [3:0] mask_o
);

    always_comb begin
        mask_o = '0;
        case (sel_i)
            ADD:     mask_o[FLG_CARRY]   = flags_i[FLG_CARRY];
            SUB:     mask_o[FLG_BORROW]  = flags_i[FLG_BORROW];
            MUL:     mask_o[FLG_MUL_OVF] = flags_i[FLG_MUL_OVF];
            DIV:     mask_o[FLG_DIVZ]    = flags_i[FLG_DIVZ];
            default: mask_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - 2-entry registered buffer behind the ALU with sticky per-op exception flags
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int M = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_buffer_if.slave  bus,
    input  logic                sticky_clr,
    output logic [3:0]          sticky_flags,
    output logic [1:0]          level
);

    buf_state_e   state_q, state_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [M-1:0] mem_result_q [2];
    logic [3:0]   mem_flags_q  [2];
    logic [3:0]   mem_sel_q    [2];
    logic [3:0]   sticky_q, sticky_d;
    logic [3:0]   filt_mask;
    logic         push, pop;

    // Ready comes only from the state register so out_ready never reaches in_ready.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    alu_flag_filter u_filter (
        .sel_i   (bus.in_sel),
        .flags_i (bus.in_flags),
        .mask_o  (filt_mask)
    );

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Clear first, then the filtered bit of a same-cycle push is set.
    always_comb begin
        sticky_d = (sticky_clr ? 4'b0000 : sticky_q) | (push ? filt_mask : 4'b0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            sticky_q <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_result_q[i] <= '0;
                mem_flags_q[i]  <= '0;
                mem_sel_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            sticky_q <= sticky_d;
            if (push) begin
                mem_result_q[wr_ptr_q] <= bus.in_result;
                mem_flags_q[wr_ptr_q]  <= bus.in_flags;
                mem_sel_q[wr_ptr_q]    <= bus.in_sel;
            end
        end
    end

    assign bus.out_result = mem_result_q[rd_ptr_q];
    assign bus.out_flags  = mem_flags_q[rd_ptr_q];
    assign bus.out_sel    = mem_sel_q[rd_ptr_q];
    assign sticky_flags   = sticky_q;
    assign level          = level_of(state_q);

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sticky_clr = 1'b0;
    logic [3:0] sticky_flags;
    logic [1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_buffer_if #(.M(32)) bus ();

    alu_result_buffer #(.M(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .level        (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  sel;
    } entry_t;

    entry_t     mq[$];
    logic [3:0] m_sticky = 4'b0000;
    int         push_count = 0;
    int         pop_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of at most two entries plus the sticky rule.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_sticky = 4'b0000;
        end else begin
            automatic bit do_push = bus.in_valid && (mq.size() < 2);
            automatic bit do_pop  = bus.out_ready && (mq.size() > 0);
            automatic entry_t e;
            if (sticky_clr) m_sticky = 4'b0000;
            if (do_push) begin
                case (bus.in_sel)
                    4'd0: m_sticky[1] = m_sticky[1] | bus.in_flags[1];
                    4'd1: m_sticky[3] = m_sticky[3] | bus.in_flags[3];
                    4'd2: m_sticky[0] = m_sticky[0] | bus.in_flags[0];
                    4'd3: m_sticky[2] = m_sticky[2] | bus.in_flags[2];
                    default: ;
                endcase
            end
            if (do_pop) begin
                void'(mq.pop_front());
                pop_count++;
            end
            if (do_push) begin
                e.result = bus.in_result;
                e.flags  = bus.in_flags;
                e.sel    = bus.in_sel;
                mq.push_back(e);
                push_count++;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("cmp_in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        check("cmp_level", 32'(level), 32'(mq.size()));
        check("cmp_sticky", 32'(sticky_flags), 32'(m_sticky));
        if (level > 2'd2) check("level_bound", 32'(level), 32'd2);
        if (mq.size() != 0) begin
            check("cmp_out_result", bus.out_result, mq[0].result);
            check("cmp_out_flags", 32'(bus.out_flags), 32'(mq[0].flags));
            check("cmp_out_sel", 32'(bus.out_sel), 32'(mq[0].sel));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] r, input logic [3:0] s, input logic [3:0] f);
        bus.in_valid  = 1'b1;
        bus.in_result = r;
        bus.in_sel    = s;
        bus.in_flags  = f;
    endtask

    initial begin
        int start, cyc;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_flags  = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);

        // Single pass
        bus.out_ready = 1'b1;
        offer(32'h5, 4'd0, 4'b0000);
        step();
        bus.in_valid = 1'b0;
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_result", bus.out_result, 32'h5);
        step();
        check("single_level", 32'(level), 32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        offer(32'hA, 4'd4, 4'b0000);
        step();
        offer(32'hB, 4'd4, 4'b0000);
        step();
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_level2", 32'(level), 32'd2);
        offer(32'hC, 4'd4, 4'b0000);
        step();
        check("bp_hold_level", 32'(level), 32'd2);
        check("bp_hold_head", bus.out_result, 32'hA);
        bus.out_ready = 1'b1;
        step();
        check("bp_second", bus.out_result, 32'hB);
        check("bp_level1", 32'(level), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_third", bus.out_result, 32'hC);
        step();
        check("bp_drained", 32'(level), 32'd0);

        // Flag filter and clear race
        offer(32'h1, 4'd1, 4'b1111);
        step();
        check("filt_sub", 32'(sticky_flags), 32'h8);
        offer(32'h2, 4'd5, 4'b1111);
        step();
        check("filt_and", 32'(sticky_flags), 32'h8);
        offer(32'h3, 4'd2, 4'b0001);
        step();
        check("filt_mul", 32'(sticky_flags), 32'h9);
        sticky_clr = 1'b1;
        offer(32'h4, 4'd3, 4'b0100);
        step();
        check("clr_race", 32'(sticky_flags), 32'h4);
        bus.in_valid = 1'b0;
        step();
        sticky_clr = 1'b0;
        check("clr_only", 32'(sticky_flags), 32'h0);
        offer(32'hDEAD_BEEF, 4'd12, 4'b1010);
        step();
        bus.in_valid = 1'b0;
        check("sel12_sel", 32'(bus.out_sel), 32'd12);
        check("sel12_flags", 32'(bus.out_flags), 32'hA);
        check("sel12_sticky", 32'(sticky_flags), 32'h0);
        step();

        // Streaming
        start = push_count;
        cyc = 0;
        while (push_count < start + 100 && cyc < 2000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_result = $urandom;
            bus.in_flags  = 4'($urandom_range(0, 15));
            bus.in_sel    = 4'($urandom_range(0, 15));
            sticky_clr    = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            step();
            cyc++;
        end
        check("stream_pushes", 32'(push_count - start), 32'd100);
        bus.in_valid  = 1'b0;
        sticky_clr    = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        check("stream_drain_level", 32'(level), 32'd0);
        check("stream_no_loss", 32'(pop_count), 32'(push_count));

        // Asynchronous reset with two entries held
        bus.out_ready = 1'b0;
        offer(32'h11, 4'd0, 4'b0010);
        step();
        offer(32'h22, 4'd1, 4'b1000);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_level", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_sticky", 32'(sticky_flags), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
